// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard detection and operand forwarding for the 5-stage pipeline.
// A shadow copy of the EXE/MEM destination registers drives the forwarding selects
// and the load-use stall. A small scoreboard tracks one in-flight MUL/DIV operation.
// Optional build macro: HAZARD_FWD_EN. When it is undefined, forwarding is disabled
// and every EXE/MEM dependency stalls until the producer has written back.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no MUL/DIV in flight
// BUSY  | MUL/DIV in flight; counter holds the remaining cycles
module pipe_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int MD_LAT = 8,
    parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_store,
    input  logic              id_wb_wen,
    input  logic [ADDR_W-1:0] id_wb_addr,
    input  logic [1:0]        id_class,
    output logic [1:0]        exe_fwd_a,
    output logic [1:0]        exe_fwd_b,
    output logic              mem_fwd_m,
    output logic              stall,
    output logic              md_start,
    output logic              md_busy,
    output logic              md_done,
    output logic [ADDR_W-1:0] md_addr
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULDIV = 2'd2;

    logic              exe_wen, exe_ld, mem_wen, mem_ld;
    logic [ADDR_W-1:0] exe_addr, mem_addr;

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] md_addr_q, md_addr_d;

    logic rs_exe, rs_mem, rt_exe, rt_mem;
    logic lu_stall, md_stall, id_is_md;

    assign rs_exe = exe_wen && (exe_addr != '0) && (exe_addr == id_rs_addr) && id_rs_used;
    assign rs_mem = mem_wen && (mem_addr != '0) && (mem_addr == id_rs_addr) && id_rs_used;
    assign rt_exe = exe_wen && (exe_addr != '0) && (exe_addr == id_rt_addr) && id_rt_used;
    assign rt_mem = mem_wen && (mem_addr != '0) && (mem_addr == id_rt_addr) && id_rt_used;

    assign id_is_md = (id_class == CLS_MULDIV);
    assign md_busy  = (state_q == BUSY);
    assign md_done  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
    assign md_addr  = md_addr_q;

    // On the done cycle the result is written back, so readers no longer wait.
    assign md_stall = md_busy && !md_done &&
                      (((md_addr_q != '0) &&
                        ((id_rs_used && (id_rs_addr == md_addr_q)) ||
                         (id_rt_used && (id_rt_addr == md_addr_q)) ||
                         (id_wb_wen && (id_wb_addr == md_addr_q)))) ||
                       id_is_md);

    assign stall    = id_valid && (lu_stall || md_stall);
    assign md_start = id_valid && id_is_md && !stall;

    // Forwarding selects and load-use stall from the shadow slots; EXE match has priority.
    always_comb begin
        exe_fwd_a = 2'd3;
        exe_fwd_b = 2'd3;
        mem_fwd_m = 1'b0;
        lu_stall  = 1'b0;
`ifdef HAZARD_FWD_EN
        if (rs_exe) begin
            if (exe_ld) begin
                lu_stall  = 1'b1;
                exe_fwd_a = 2'd2;
            end else begin
                exe_fwd_a = 2'd0;
            end
        end else if (rs_mem) begin
            exe_fwd_a = mem_ld ? 2'd2 : 2'd1;
        end

        if (rt_exe) begin
            if (exe_ld) begin
                // Store data can be picked up from the load result in MEM next cycle.
                if (id_is_store) begin
                    mem_fwd_m = 1'b1;
                end else begin
                    lu_stall  = 1'b1;
                    exe_fwd_b = 2'd2;
                end
            end else begin
                exe_fwd_b = 2'd0;
            end
        end else if (rt_mem) begin
            exe_fwd_b = mem_ld ? 2'd2 : 2'd1;
        end
`else
        lu_stall = rs_exe || rs_mem || rt_exe || rt_mem;
`endif
    end

`ifndef HAZARD_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^{id_is_store, exe_ld, mem_ld};
`endif

    // Shadow pipeline: MEM follows EXE; stalled or invalid ID inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_wen  <= 1'b0;
            exe_addr <= '0;
            exe_ld   <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_ld   <= 1'b0;
        end else begin
            mem_wen  <= exe_wen;
            mem_addr <= exe_addr;
            mem_ld   <= exe_ld;
            if (stall || !id_valid) begin
                exe_wen  <= 1'b0;
                exe_addr <= '0;
                exe_ld   <= 1'b0;
            end else begin
                exe_wen  <= id_wb_wen && !id_is_md;
                exe_addr <= id_wb_addr;
                exe_ld   <= (id_class == CLS_LOAD);
            end
        end
    end

    // MUL/DIV scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_addr_q <= md_addr_d;
        end
    end

    // MUL/DIV next state; an issue on the done cycle reloads without leaving BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_addr_d = md_addr_q;
        if (state_q == BUSY) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        if (md_start) begin
            state_d   = BUSY;
            cnt_d     = CNT_W'(MD_LAT);
            md_addr_d = id_wb_addr;
        end
    end

endmodule
